// File: rtl/dpll_lock_ctrl.sv
// Acquisition and lock controller for the Manchester bit-clock DPLL: flushes the DPLL,
// classifies each transition against the DPLL period boundary, and declares or drops lock.
module dpll_lock_ctrl #(
  parameter int unsigned COUNTER_WIDTH   = 16,
  parameter int unsigned WINDOW          = 2,
  parameter int unsigned LOCK_COUNT      = 8,
  parameter int unsigned UNLOCK_COUNT    = 4,
  parameter int unsigned TIMEOUT_PERIODS = 4,
  parameter int unsigned MAX_ACQ_SLEWS   = 64,
  parameter int unsigned RST_CYCLES      = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [COUNTER_WIDTH-1:0] nominal_div,
  input  logic                     slew,
  input  logic                     clr,
  input  logic [COUNTER_WIDTH-1:0] period,
  output logic [COUNTER_WIDTH-1:0] div,
  output logic                     dpll_rst,
  output logic                     locked,
  output logic                     lock_lost,
  output logic                     acq_retry,
  output logic [1:0]               state
);

  localparam int unsigned EXT_W  = COUNTER_WIDTH + 1;
  localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int unsigned BAD_W  = $clog2(UNLOCK_COUNT + 1);
  localparam int unsigned SIL_W  = $clog2(TIMEOUT_PERIODS + 1);
  localparam int unsigned ACQ_W  = $clog2(MAX_ACQ_SLEWS + 1);
  localparam int unsigned CYC_W  = $clog2(RST_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FLUSH   = 2'd1,
    S_ACQUIRE = 2'd2,
    S_LOCKED  = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [COUNTER_WIDTH-1:0] ph_q, ph_d;
  logic [COUNTER_WIDTH-1:0] div_d;
  logic [GOOD_W-1:0]        good_q, good_d, good_inc_c;
  logic [BAD_W-1:0]         bad_q, bad_d, bad_inc_c;
  logic [SIL_W-1:0]         sil_q, sil_d;
  logic [ACQ_W-1:0]         acq_q, acq_d, acq_inc_c;
  logic [CYC_W-1:0]         cyc_q, cyc_d;
  logic                     dpll_rst_d, locked_d, lock_lost_d, acq_retry_d;
  logic                     running_c, slew_good_c, timeout_c;
  logic                     good_event_c, bad_event_c, flush_entry_c;
  logic [EXT_W-1:0]         ph_ext_c, per_ext_c, win_ext_c, lo_bound_c;

  assign state = state_q;

  // Phase tracking, slew classification and silence (timeout) detection.
  always_comb begin
    running_c   = (state_q == S_ACQUIRE) || (state_q == S_LOCKED);
    ph_ext_c    = {1'b0, ph_q};
    per_ext_c   = {1'b0, period};
    win_ext_c   = EXT_W'(WINDOW);
    lo_bound_c  = (per_ext_c > win_ext_c) ? (per_ext_c - win_ext_c) : '0;
    slew_good_c = clr || (ph_ext_c <= win_ext_c) || (ph_ext_c >= lo_bound_c);

    ph_d = '0;
    if (running_c && !clr) begin
      ph_d = (ph_q == '1) ? ph_q : (ph_q + COUNTER_WIDTH'(1));
    end

    sil_d     = '0;
    timeout_c = 1'b0;
    if (running_c && !slew) begin
      sil_d = sil_q;
      if (clr) begin
        if ((sil_q + SIL_W'(1)) == SIL_W'(TIMEOUT_PERIODS)) begin
          timeout_c = 1'b1;
          sil_d     = '0;
        end else begin
          sil_d = sil_q + SIL_W'(1);
        end
      end
    end

    good_event_c = running_c && slew && slew_good_c;
    bad_event_c  = running_c && ((slew && !slew_good_c) || timeout_c);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    div_d         = div;
    good_d        = good_q;
    bad_d         = bad_q;
    acq_d         = acq_q;
    cyc_d         = cyc_q;
    lock_lost_d   = 1'b0;
    acq_retry_d   = 1'b0;
    flush_entry_c = 1'b0;
    good_inc_c    = good_q + GOOD_W'(1);
    bad_inc_c     = bad_q + BAD_W'(1);
    acq_inc_c     = acq_q + ACQ_W'(1);

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d       = S_FLUSH;
          flush_entry_c = 1'b1;
        end
      end
      S_FLUSH: begin
        if (cyc_q <= CYC_W'(1)) begin
          state_d = S_ACQUIRE;
          good_d  = '0;
          bad_d   = '0;
          acq_d   = '0;
        end else begin
          cyc_d = cyc_q - CYC_W'(1);
        end
      end
      S_ACQUIRE: begin
        if (slew) begin
          acq_d  = acq_inc_c;
          good_d = slew_good_c ? good_inc_c : '0;
        end else if (timeout_c) begin
          good_d = '0;
        end
        // Lock wins over the retry limit when both land on the same slew.
        if (good_event_c && (good_inc_c == GOOD_W'(LOCK_COUNT))) begin
          state_d = S_LOCKED;
          bad_d   = '0;
        end else if (slew && (acq_inc_c == ACQ_W'(MAX_ACQ_SLEWS))) begin
          state_d       = S_FLUSH;
          acq_retry_d   = 1'b1;
          flush_entry_c = 1'b1;
        end
      end
      S_LOCKED: begin
        if (good_event_c) begin
          bad_d = '0;
        end else if (bad_event_c) begin
          bad_d = bad_inc_c;
          if (bad_inc_c == BAD_W'(UNLOCK_COUNT)) begin
            state_d       = S_FLUSH;
            lock_lost_d   = 1'b1;
            flush_entry_c = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Disable overrides everything and is a silent return to IDLE.
    if (!enable) begin
      state_d       = S_IDLE;
      lock_lost_d   = 1'b0;
      acq_retry_d   = 1'b0;
      flush_entry_c = 1'b0;
    end

    if (flush_entry_c) begin
      div_d = nominal_div;
      cyc_d = CYC_W'(RST_CYCLES);
    end

    locked_d   = (state_d == S_LOCKED);
    dpll_rst_d = !((state_d == S_ACQUIRE) || (state_d == S_LOCKED));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      div       <= '0;
      dpll_rst  <= 1'b1;
      locked    <= 1'b0;
      lock_lost <= 1'b0;
      acq_retry <= 1'b0;
      ph_q      <= '0;
      good_q    <= '0;
      bad_q     <= '0;
      sil_q     <= '0;
      acq_q     <= '0;
      cyc_q     <= '0;
    end else begin
      state_q   <= state_d;
      div       <= div_d;
      dpll_rst  <= dpll_rst_d;
      locked    <= locked_d;
      lock_lost <= lock_lost_d;
      acq_retry <= acq_retry_d;
      ph_q      <= ph_d;
      good_q    <= good_d;
      bad_q     <= bad_d;
      sil_q     <= sil_d;
      acq_q     <= acq_d;
      cyc_q     <= cyc_d;
    end
  end

endmodule
